// File: rtl/mbldcm_csr_pkg.sv
// Shared definitions for the BLDC motor control/status register slave:
// register map, CTRL/STATUS bit positions and reset values.
package mbldcm_csr_pkg;

    typedef enum logic [2:0] {
        ADDR_CTRL     = 3'd0,
        ADDR_DIV      = 3'd1,
        ADDR_PHASE    = 3'd2,
        ADDR_PWM_MAX  = 3'd3,
        ADDR_PWM_CMP  = 3'd4,
        ADDR_PWM_PRSC = 3'd5,
        ADDR_STATUS   = 3'd6,
        ADDR_STEP_CNT = 3'd7
    } regAddr_t;

    localparam int unsigned CTRL_ENABLE_BIT   = 0;
    localparam int unsigned CTRL_STOP_BIT     = 1;
    localparam int unsigned CTRL_COMMIT_BIT   = 8;

    localparam int unsigned STATUS_ACCEPT_BIT = 0;
    localparam int unsigned STATUS_ERROR_BIT  = 1;

    localparam int unsigned PRSC_WIDTH        = 6;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic RST_STOP   = 1'b1;

endpackage

// File: rtl/mbldcm_csr_if.sv
// Single-clock memory-mapped bus into the CSR block; reads return one cycle
// after the strobe.
interface mbldcm_csr_if;

    logic [2:0]  iAddress;
    logic        iWrite;
    logic [31:0] iWriteData;
    logic        iRead;
    logic [31:0] oReadData;

    modport master (
        output iAddress, iWrite, iWriteData, iRead,
        input  oReadData
    );

    modport slave (
        input  iAddress, iWrite, iWriteData, iRead,
        output oReadData
    );

endinterface

// File: rtl/mbldcm_step_counter.sv
// Counts commutation steps: one increment per cycle in which the core phase
// differs from the previous cycle's phase. A clear beats a coincident step.
module mbldcm_step_counter (
    input  logic        iClock,
    input  logic        iReset_n,
    input  logic [2:0]  iPhase,
    input  logic        iClear,
    output logic [31:0] oCount
);

    logic [2:0]  prevPhase;
    logic [31:0] count;
    logic [31:0] countNext;

    always_comb begin
        countNext = count;
        if (iClear)
            countNext = '0;
        else if (iPhase != prevPhase)
            countNext = count + 32'd1;
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            count     <= '0;
            prevPhase <= '0;
        end else begin
            count     <= countNext;
            prevPhase <= iPhase;
        end
    end

    assign oCount = count;

endmodule

// File: rtl/mbldcm_csr.sv
// Control/status register slave driving the BLDC motor core, with
// double-buffered PWM settings committed only when compare <= period.
module mbldcm_csr
    import mbldcm_csr_pkg::*;
#(
    parameter int unsigned pPwmCounterWidth = 32
) (
    input  logic                        iClock,
    input  logic                        iReset_n,
    mbldcm_csr_if.slave                 bus,
    input  logic [2:0]                  iPhase,
    output logic                        oEnable,
    output logic                        oStop,
    output logic [31:0]                 oDiv,
    output logic [2:0]                  oPhaseUpdate,
    output logic                        oLatchPhaseUpdate,
    output logic [pPwmCounterWidth-1:0] oPwmMaxCnt,
    output logic [pPwmCounterWidth-1:0] oPwmCmpCnt,
    output logic [PRSC_WIDTH-1:0]       oPwmPrscSel
);

    regAddr_t                    addr;
    logic                        wrCtrl, wrDiv, wrPhase, wrMax, wrCmp, wrPrsc, wrStatus, wrStepCnt;
    logic                        commitReq, commitOk;
    logic [pPwmCounterWidth-1:0] shadowMax, shadowCmp;
    logic [PRSC_WIDTH-1:0]       shadowPrsc;
    logic                        statusAccept, statusError;
    logic [31:0]                 stepCount;
    logic [31:0]                 readMux;

    assign addr      = regAddr_t'(bus.iAddress);
    assign wrCtrl    = bus.iWrite && (addr == ADDR_CTRL);
    assign wrDiv     = bus.iWrite && (addr == ADDR_DIV);
    assign wrPhase   = bus.iWrite && (addr == ADDR_PHASE);
    assign wrMax     = bus.iWrite && (addr == ADDR_PWM_MAX);
    assign wrCmp     = bus.iWrite && (addr == ADDR_PWM_CMP);
    assign wrPrsc    = bus.iWrite && (addr == ADDR_PWM_PRSC);
    assign wrStatus  = bus.iWrite && (addr == ADDR_STATUS);
    assign wrStepCnt = bus.iWrite && (addr == ADDR_STEP_CNT);

    assign commitReq = wrCtrl && bus.iWriteData[CTRL_COMMIT_BIT];
    assign commitOk  = (shadowCmp <= shadowMax);

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            oEnable           <= RST_ENABLE;
            oStop             <= RST_STOP;
            oDiv              <= '0;
            oPhaseUpdate      <= '0;
            oLatchPhaseUpdate <= 1'b0;
        end else begin
            oLatchPhaseUpdate <= wrPhase;
            if (wrCtrl) begin
                oEnable <= bus.iWriteData[CTRL_ENABLE_BIT];
                oStop   <= bus.iWriteData[CTRL_STOP_BIT];
            end
            if (wrDiv)
                oDiv <= bus.iWriteData;
            if (wrPhase)
                oPhaseUpdate <= bus.iWriteData[2:0];
        end
    end

    // Shadow -> active transfer is all-or-nothing so the core never sees a
    // mixed old/new PWM configuration.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            shadowMax    <= '0;
            shadowCmp    <= '0;
            shadowPrsc   <= '0;
            oPwmMaxCnt   <= '0;
            oPwmCmpCnt   <= '0;
            oPwmPrscSel  <= '0;
            statusAccept <= 1'b0;
            statusError  <= 1'b0;
        end else begin
            if (wrMax)
                shadowMax <= bus.iWriteData[pPwmCounterWidth-1:0];
            if (wrCmp)
                shadowCmp <= bus.iWriteData[pPwmCounterWidth-1:0];
            if (wrPrsc)
                shadowPrsc <= bus.iWriteData[PRSC_WIDTH-1:0];
            if (commitReq) begin
                statusAccept <= commitOk;
                if (commitOk) begin
                    oPwmMaxCnt  <= shadowMax;
                    oPwmCmpCnt  <= shadowCmp;
                    oPwmPrscSel <= shadowPrsc;
                end else begin
                    statusError <= 1'b1;
                end
            end
            if (wrStatus && bus.iWriteData[STATUS_ERROR_BIT])
                statusError <= 1'b0;
        end
    end

    mbldcm_step_counter uStepCounter (
        .iClock   (iClock),
        .iReset_n (iReset_n),
        .iPhase   (iPhase),
        .iClear   (wrStepCnt),
        .oCount   (stepCount)
    );

    always_comb begin
        readMux = '0;
        case (addr)
            ADDR_CTRL: begin
                readMux[CTRL_ENABLE_BIT] = oEnable;
                readMux[CTRL_STOP_BIT]   = oStop;
            end
            ADDR_DIV:      readMux = oDiv;
            ADDR_PHASE:    readMux = {29'd0, iPhase};
            ADDR_PWM_MAX:  readMux = 32'(shadowMax);
            ADDR_PWM_CMP:  readMux = 32'(shadowCmp);
            ADDR_PWM_PRSC: readMux = 32'(shadowPrsc);
            ADDR_STATUS: begin
                readMux[STATUS_ACCEPT_BIT] = statusAccept;
                readMux[STATUS_ERROR_BIT]  = statusError;
            end
            ADDR_STEP_CNT: readMux = stepCount;
        endcase
    end

    // The mux sees pre-write state, so a read paired with a write returns the old value.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n)
            bus.oReadData <= '0;
        else if (bus.iRead)
            bus.oReadData <= readMux;
    end

endmodule

// File: tb/tb_mbldcm_csr.sv
// Directed bench for mbldcm_csr: a 32-bit PWM instance for the main flow and
// a 16-bit instance for write truncation.
module tb_mbldcm_csr;
    import mbldcm_csr_pkg::*;

    logic        clk;
    logic        rstN;
    logic [2:0]  phase;
    int unsigned nCompared;
    int unsigned nMismatched;
    logic [31:0] rd;

    logic        en32, stop32, latch32;
    logic [31:0] div32, max32, cmp32;
    logic [2:0]  phUpd32;
    logic [5:0]  prsc32;

    logic        en16, stop16, latch16;
    logic [31:0] div16;
    logic [15:0] max16, cmp16;
    logic [2:0]  phUpd16;
    logic [5:0]  prsc16;

    mbldcm_csr_if bus32 ();
    mbldcm_csr_if bus16 ();

    mbldcm_csr #(.pPwmCounterWidth(32)) dut32 (
        .iClock            (clk),
        .iReset_n          (rstN),
        .bus               (bus32.slave),
        .iPhase            (phase),
        .oEnable           (en32),
        .oStop             (stop32),
        .oDiv              (div32),
        .oPhaseUpdate      (phUpd32),
        .oLatchPhaseUpdate (latch32),
        .oPwmMaxCnt        (max32),
        .oPwmCmpCnt        (cmp32),
        .oPwmPrscSel       (prsc32)
    );

    mbldcm_csr #(.pPwmCounterWidth(16)) dut16 (
        .iClock            (clk),
        .iReset_n          (rstN),
        .bus               (bus16.slave),
        .iPhase            (phase),
        .oEnable           (en16),
        .oStop             (stop16),
        .oDiv              (div16),
        .oPhaseUpdate      (phUpd16),
        .oLatchPhaseUpdate (latch16),
        .oPwmMaxCnt        (max16),
        .oPwmCmpCnt        (cmp16),
        .oPwmPrscSel       (prsc16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp)
        else begin
            nMismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic busSet(input bit sel, input logic [2:0] a, input logic w,
                          input logic [31:0] d, input logic r);
        if (sel) begin
            bus16.iAddress = a; bus16.iWrite = w; bus16.iWriteData = d; bus16.iRead = r;
        end else begin
            bus32.iAddress = a; bus32.iWrite = w; bus32.iWriteData = d; bus32.iRead = r;
        end
    endtask

    task automatic writeReg(input bit sel, input logic [2:0] a, input logic [31:0] d);
        busSet(sel, a, 1'b1, d, 1'b0);
        @(negedge clk);
        busSet(sel, 3'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic readReg(input bit sel, input logic [2:0] a, output logic [31:0] d);
        busSet(sel, a, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        busSet(sel, 3'd0, 1'b0, 32'd0, 1'b0);
        d = sel ? bus16.oReadData : bus32.oReadData;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rstN  = 1'b0;
        phase = 3'd0;
        busSet(1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
        busSet(1'b1, 3'd0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        // Reset state
        check("rst_enable", 32'(en32), 32'd0);
        check("rst_stop", 32'(stop32), 32'd1);
        check("rst_div", div32, 32'd0);
        check("rst_phupd", 32'(phUpd32), 32'd0);
        check("rst_latch", 32'(latch32), 32'd0);
        check("rst_max", max32, 32'd0);
        check("rst_cmp", cmp32, 32'd0);
        check("rst_prsc", 32'(prsc32), 32'd0);
        check("rst_rdata", bus32.oReadData, 32'd0);
        readReg(1'b0, ADDR_STATUS, rd);
        check("rst_status", rd, 32'd0);

        // Shadow writes do not reach active outputs until COMMIT
        writeReg(1'b0, ADDR_PWM_MAX, 32'd1000);
        writeReg(1'b0, ADDR_PWM_CMP, 32'd250);
        writeReg(1'b0, ADDR_PWM_PRSC, 32'd3);
        check("pre_commit_max", max32, 32'd0);
        check("pre_commit_cmp", cmp32, 32'd0);
        writeReg(1'b0, ADDR_DIV, 32'h55);
        check("div_write", div32, 32'h55);
        writeReg(1'b0, ADDR_CTRL, 32'h101);
        check("commit_max", max32, 32'd1000);
        check("commit_cmp", cmp32, 32'd250);
        check("commit_prsc", 32'(prsc32), 32'd3);
        check("commit_enable", 32'(en32), 32'd1);
        check("commit_stop", 32'(stop32), 32'd0);
        readReg(1'b0, ADDR_STATUS, rd);
        check("status_accept", rd, 32'h1);
        readReg(1'b0, ADDR_CTRL, rd);
        check("ctrl_readback", rd, 32'h1);
        readReg(1'b0, ADDR_PWM_PRSC, rd);
        check("prsc_shadow_rd", rd, 32'd3);

        // Rejected commit: CMP > MAX
        writeReg(1'b0, ADDR_PWM_CMP, 32'd2000);
        writeReg(1'b0, ADDR_CTRL, 32'h101);
        check("reject_max", max32, 32'd1000);
        check("reject_cmp", cmp32, 32'd250);
        readReg(1'b0, ADDR_STATUS, rd);
        check("status_error", rd, 32'h2);
        writeReg(1'b0, ADDR_STATUS, 32'h2);
        readReg(1'b0, ADDR_STATUS, rd);
        check("status_w1c", rd, 32'h0);

        // Boundary: CMP == MAX is accepted
        writeReg(1'b0, ADDR_PWM_CMP, 32'd1000);
        writeReg(1'b0, ADDR_CTRL, 32'h101);
        check("equal_cmp", cmp32, 32'd1000);

        // Phase preload pulse, single then back-to-back
        writeReg(1'b0, ADDR_PHASE, 32'd5);
        check("phase_upd", 32'(phUpd32), 32'd5);
        check("latch_pulse", 32'(latch32), 32'd1);
        @(negedge clk);
        check("latch_drop", 32'(latch32), 32'd0);
        busSet(1'b0, ADDR_PHASE, 1'b1, 32'd2, 1'b0);
        @(negedge clk);
        check("b2b_latch1", 32'(latch32), 32'd1);
        check("b2b_upd1", 32'(phUpd32), 32'd2);
        busSet(1'b0, ADDR_PHASE, 1'b1, 32'd6, 1'b0);
        @(negedge clk);
        busSet(1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
        check("b2b_latch2", 32'(latch32), 32'd1);
        check("b2b_upd2", 32'(phUpd32), 32'd6);
        @(negedge clk);
        check("b2b_drop", 32'(latch32), 32'd0);
        phase = 3'd3;
        readReg(1'b0, ADDR_PHASE, rd);
        check("phase_read", rd, 32'd3);

        // Read and write in the same cycle returns the pre-write value
        busSet(1'b0, ADDR_DIV, 1'b1, 32'h77, 1'b1);
        @(negedge clk);
        busSet(1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
        check("rw_old_value", bus32.oReadData, 32'h55);
        check("rw_new_div", div32, 32'h77);
        @(negedge clk);
        check("rdata_held", bus32.oReadData, 32'h55);

        // Step counter: three changes
        phase = 3'd0;
        @(negedge clk);
        writeReg(1'b0, ADDR_STEP_CNT, 32'd0);
        phase = 3'd1;
        @(negedge clk);
        phase = 3'd2;
        @(negedge clk);
        phase = 3'd3;
        @(negedge clk);
        readReg(1'b0, ADDR_STEP_CNT, rd);
        check("step_three", rd, 32'd3);

        // Wrap from all-ones
        force dut32.uStepCounter.count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut32.uStepCounter.count;
        readReg(1'b0, ADDR_STEP_CNT, rd);
        check("step_preload", rd, 32'hFFFF_FFFF);
        phase = 3'd4;
        @(negedge clk);
        readReg(1'b0, ADDR_STEP_CNT, rd);
        check("step_wrap", rd, 32'd0);

        // Clear coincident with a phase change
        phase = 3'd6;
        @(negedge clk);
        readReg(1'b0, ADDR_STEP_CNT, rd);
        check("step_one", rd, 32'd1);
        phase = 3'd7;
        writeReg(1'b0, ADDR_STEP_CNT, 32'hDEAD);
        readReg(1'b0, ADDR_STEP_CNT, rd);
        check("step_clear_wins", rd, 32'd0);

        // Reset in the middle of a PHASE write: no pulse, everything back to reset values
        busSet(1'b0, ADDR_PHASE, 1'b1, 32'd7, 1'b0);
        rstN = 1'b0;
        @(negedge clk);
        busSet(1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
        check("midrst_latch", 32'(latch32), 32'd0);
        check("midrst_phupd", 32'(phUpd32), 32'd0);
        check("midrst_enable", 32'(en32), 32'd0);
        check("midrst_stop", 32'(stop32), 32'd1);
        check("midrst_max", max32, 32'd0);
        check("midrst_div", div32, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        readReg(1'b0, ADDR_PWM_MAX, rd);
        check("midrst_shadow", rd, 32'd0);

        // 16-bit instance: truncation of shadow writes
        writeReg(1'b1, ADDR_PWM_MAX, 32'h1234_5678);
        writeReg(1'b1, ADDR_PWM_PRSC, 32'hFF);
        writeReg(1'b1, ADDR_CTRL, 32'h100);
        check("w16_max", 32'(max16), 32'h5678);
        check("w16_cmp", 32'(cmp16), 32'd0);
        check("w16_prsc", 32'(prsc16), 32'h3F);
        readReg(1'b1, ADDR_PWM_MAX, rd);
        check("w16_shadow_rd", rd, 32'h0000_5678);
        readReg(1'b1, ADDR_STATUS, rd);
        check("w16_status", rd, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mbldcm_csr.md
# mbldcm_csr

Control/status register slave sitting directly upstream of the BLDC motor core. It decodes a single-clock memory-mapped bus (fixed read latency 1) and drives every control input of the core: enable, stop, divider, phase preload with latch pulse, and PWM settings. PWM settings are double-buffered (shadow + active) with a validated commit. It also counts commutation steps by watching the core's phase output.

## Interface
- pPwmCounterWidth, 32, width of PWM max/compare outputs (1..32)
- iClock  in  1  system clock
- iReset_n  in  1  asynchronous active-low reset
- iAddress  in  3  word address
- iWrite  in  1  write strobe
- iWriteData  in  32  write data
- iRead  in  1  read strobe
- oReadData  out  32  read data, valid the cycle after iRead
- iPhase  in  3  current phase from core
- oEnable  out  1  output enable to core
- oStop  out  1  phase stepping stop
- oDiv  out  32  phase-step divider
- oPhaseUpdate  out  3  phase preload value
- oLatchPhaseUpdate  out  1  one-cycle preload pulse
- oPwmMaxCnt  out  pPwmCounterWidth  active PWM period
- oPwmCmpCnt  out  pPwmCounterWidth  active PWM compare
- oPwmPrscSel  out  6  active prescaler select

## Operation
- Register map (word address): 0 CTRL, 1 DIV, 2 PHASE, 3 PWM_MAX shadow, 4 PWM_CMP shadow, 5 PWM_PRSC shadow, 6 STATUS, 7 STEP_CNT.
- CTRL: bit0 enable (RW), bit1 stop (RW), bit8 COMMIT (write-1 action, reads 0).
- DIV: 32-bit RW, drives oDiv directly.
- PHASE write: bits[2:0] -> oPhaseUpdate; oLatchPhaseUpdate pulses high exactly one cycle. PHASE read: returns iPhase zero-extended.
- Shadow regs 3..5: RW, no effect on outputs until COMMIT. Writes truncated to pPwmCounterWidth (prescaler to 6 bits); reads zero-extended.
- COMMIT: if shadow CMP <= shadow MAX, all three shadows copy to active outputs together; else active unchanged and STATUS.bit1 (commit error, sticky) sets. STATUS.bit0 = last commit accepted.
- STATUS write: bit1 write-1-to-clear; other bits ignored.
- STEP_CNT: 32-bit, +1 each cycle iPhase differs from its registered previous value; wraps 0xFFFFFFFF -> 0. Any write clears to 0.
- Unmapped bits read 0.

## Timing
- Reset values: oEnable 0, oStop 1, oDiv 0, oPhaseUpdate 0, oLatchPhaseUpdate 0, oPwmMaxCnt 0, oPwmCmpCnt 0, oPwmPrscSel 0, oReadData 0, shadows 0, STATUS 0, STEP_CNT 0, previous-phase register 0.
- Register writes visible on outputs the cycle after iWrite.
- oLatchPhaseUpdate asserted in the cycle after the PHASE write; back-to-back PHASE writes give back-to-back pulses.
- COMMIT: active outputs (or error bit) update the cycle after the write; COMMIT in same write as enable/stop changes applies both the same cycle.
- Read: oReadData registered, valid one cycle after iRead; held otherwise. iRead and iWrite together: write performed, read returns pre-write value.
- STEP_CNT clear and phase change in the same cycle: clear wins (result 0).
- Reset asserted mid-operation: all state to reset values immediately, no pulse emitted.

## Structure
- Shared package mbldcm_csr_pkg: register address constants, CTRL/STATUS bit positions, reset values.
- One sub-module: mbldcm_step_counter (previous-phase register, change detect, wrap counter, clear).

## Test plan
- Reset release -> oStop=1, oEnable=0, all others 0; read STATUS -> 0.
- Write MAX=1000, CMP=250, PRSC=3, then CTRL=0x101 -> outputs unchanged until COMMIT; next cycle oPwmMaxCnt=1000, oPwmCmpCnt=250, oPwmPrscSel=3, oEnable=1, STATUS=0x1.
- Shadow CMP=2000 > MAX=1000, COMMIT -> active stays 1000/250, STATUS=0x2; write STATUS 0x2 -> STATUS=0x0.
- Write PHASE=5 -> oPhaseUpdate=5, oLatchPhaseUpdate high exactly 1 cycle; read PHASE with iPhase=3 -> 3.
- Drive iPhase 0->1->2->3 over 3 changes -> STEP_CNT=3; preload 0xFFFFFFFF via force, one change -> 0; write STEP_CNT coincident with change -> 0.
- pPwmCounterWidth=16: write MAX=0x12345678, commit -> oPwmMaxCnt=0x5678 (CMP=0), read shadow -> 0x00005678.
